zkr_seed_csr: RTL and testbench
===============================

// Module: zkr_seed_csr
// PURPOSE
//  Consumer side of the Zkr entropy source: buffers 16-bit entropy words from the
//  entropy source and serves the seed CSR read-with-write access in the CSR file.
//  Each word is returned exactly once (read consumes).
//  Produces the architectural seed value {OPST[1:0], 14'b0, entropy[15:0]}.
//  Runs the BIST/WAIT/ES16/DEAD operational-status machine seen by software.
// PARAMETERS
//  FIFO_DEPTH   2    entropy words buffered; power of two, >=2
//  BIST_CYCLES  16   cycles held in BIST after reset/fatal error, >=1
// PORTS
//  clk          in   1   clock; only clock in the block
//  rst_n        in   1   asynchronous, active-low reset
//  es_valid_i   in   1   entropy word valid from source
//  es_data_i    in   16  entropy word
//  es_error_i   in   2   00 ok, 01 fatal (rerun BIST), 10 transient, 11 dead
//  es_ready_o   out  1   block accepts es_data_i this cycle
//  csr_rd_i     in   1   seed CSR access strobe, one cycle
//  csr_wr_i     in   1   access includes a write (csrrw-class)
//  access_ok_i  in   1   privilege/mseccfg check passed
//  csr_rdata_o  out  32  seed value for this access
//  illegal_o    out  1   access must trap as illegal instruction
// BEHAVIOUR
//  Reset (rst_n=0): state=BIST, FIFO empty, BIST counter=BIST_CYCLES-1,
//   es_ready_o=0, csr_rdata_o=0, illegal_o=0. Reset mid-operation drops all buffered words.
//  Handshake: push when es_valid_i & es_ready_o at posedge clk.
//   es_ready_o = !full & state!=DEAD & es_error_i==00.
//   In BIST, accepted words are discarded (source flush).
//  Access: acc = csr_rd_i & csr_wr_i & access_ok_i.
//   csr_rd_i & !acc -> illegal_o=1 that cycle, csr_rdata_o=0, no pop.
//   csr_rdata_o and illegal_o are combinational in the access cycle.
//   A pop takes effect at the following edge.
//  OPST per state:
//   BIST=00, entropy 0.
//   WAIT=01, entropy 0.
//   ES16=10, entropy = FIFO head.
//   DEAD=11, entropy 0.
//   Bits [29:16] are always 0.
//  States/transitions (priority top-down, evaluated each edge):
//   any state, es_error_i==11 -> DEAD; sticky until reset, FIFO flushed.
//   any non-DEAD state, es_error_i==01 -> BIST; FIFO flushed, counter reloaded.
//   BIST: counter decrements each cycle; at 0 -> WAIT.
//   WAIT: FIFO nonempty & es_error_i==00 -> ES16.
//   ES16: es_error_i==10 -> WAIT with FIFO flushed.
//   ES16: acc while FIFO count==1 with no push -> WAIT.
//   ES16: otherwise stay.
//  ES16 & acc: pop head.
//  WAIT/BIST/DEAD & acc: no pop, returns status only.
//   WAIT returns 0x4000_0000; BIST returns 0x0000_0000; DEAD returns 0xC000_0000.
//  Simultaneous push+pop: both occur, count unchanged.
//   If count was 1, the access returns the old word; state stays ES16.
//  Full FIFO: es_ready_o=0, source holds; no overflow possible.
//  Pointers wrap modulo FIFO_DEPTH.
//  Count is $clog2(FIFO_DEPTH)+1 bits wide.
//  Entropy field reported in ES16 is never stale: each pushed word is visible to
//   at most one acc.
// TESTING
//  1 Release rst_n; drive 0xA5A5 valid during BIST ->
//    csr reads return 0x0 for 16 cycles, then 0x4000_0000; 0xA5A5 never returned.
//  2 After BIST, push 0x1234 then 0xBEEF; two acc ->
//    0x8000_1234, 0x8000_BEEF; third acc -> 0x4000_0000.
//  3 FIFO_DEPTH=2 full, es_valid_i held with 0x5555 -> es_ready_o=0.
//    One acc -> es_ready_o=1 next cycle, 0x5555 accepted; no word lost or duplicated.
//  4 Count=1 holding 0x0F0F; acc and push 0x7777 same cycle ->
//    returns 0x8000_0F0F; next acc -> 0x8000_7777.
//  5 csr_rd_i with csr_wr_i=0, or access_ok_i=0 ->
//    illegal_o=1, rdata 0, FIFO count unchanged.
//  6 es_error_i=01 in ES16 -> BIST, FIFO empty, reads 0x0.
//    es_error_i=11 -> reads 0xC000_0000 until rst_n; rst_n low mid-ES16 -> BIST, empty.

Source files
------------

// File: rtl/zkr_seed_csr.sv
// Seed CSR consumer for the Zkr entropy source: buffers 16-bit entropy words,
// serves read-with-write seed accesses and runs the BIST/WAIT/ES16/DEAD status machine.
//
//  state | meaning
//  BIST  | self-test hold after reset or fatal error; incoming words discarded
//  WAIT  | healthy, no entropy buffered yet
//  ES16  | entropy available at FIFO head
//  DEAD  | unrecoverable source failure, sticky until reset
module zkr_seed_csr #(
  parameter int FIFO_DEPTH  = 2,
  parameter int BIST_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        es_valid_i,
  input  logic [15:0] es_data_i,
  input  logic [1:0]  es_error_i,
  output logic        es_ready_o,
  input  logic        csr_rd_i,
  input  logic        csr_wr_i,
  input  logic        access_ok_i,
  output logic [31:0] csr_rdata_o,
  output logic        illegal_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = (BIST_CYCLES > 1) ? $clog2(BIST_CYCLES) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BIST_RELOAD = BW'(BIST_CYCLES - 1);

  // Encodings double as the OPST field
  localparam logic [1:0] ST_BIST = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_ES16 = 2'b10;
  localparam logic [1:0] ST_DEAD = 2'b11;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_FATAL = 2'b01;
  localparam logic [1:0] ERR_TRANS = 2'b10;
  localparam logic [1:0] ERR_DEAD  = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [15:0]   mem [FIFO_DEPTH];

  logic full, acc, push, push_store, pop, flush;
  logic [15:0] head;

  assign full       = (count_q == FULL_CNT);
  assign es_ready_o = rst_n & ~full & (state_q != ST_DEAD) & (es_error_i == ERR_OK);
  assign push       = es_valid_i & es_ready_o;
  assign push_store = push & (state_q != ST_BIST) & ~flush;
  assign acc        = csr_rd_i & csr_wr_i & access_ok_i;
  assign pop        = acc & (state_q == ST_ES16) & ~flush;
  assign head       = mem[rd_ptr_q];
  assign illegal_o  = rst_n & csr_rd_i & ~acc;

  always_comb begin
    csr_rdata_o = 32'h0;
    if (acc) begin
      csr_rdata_o[31:30] = state_q;
      if (state_q == ST_ES16) csr_rdata_o[15:0] = head;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;
    if (es_error_i == ERR_DEAD) begin
      state_d = ST_DEAD;
      flush   = 1'b1;
    end else if (state_q != ST_DEAD && es_error_i == ERR_FATAL) begin
      state_d = ST_BIST;
      cnt_d   = BIST_RELOAD;
      flush   = 1'b1;
    end else begin
      case (state_q)
        ST_BIST: begin
          if (cnt_q == '0) state_d = ST_WAIT;
          else             cnt_d   = cnt_q - BW'(1);
        end
        ST_WAIT: begin
          if (count_q != '0 && es_error_i == ERR_OK) state_d = ST_ES16;
        end
        ST_ES16: begin
          if (es_error_i == ERR_TRANS) begin
            state_d = ST_WAIT;
            flush   = 1'b1;
          end else if (acc && count_q == CW'(1) && !push) begin
            state_d = ST_WAIT;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BIST;
      cnt_q   <= BIST_RELOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_store) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)        rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_store, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_store) mem[wr_ptr_q] <= es_data_i;
  end

endmodule

// File: tb/tb_zkr_seed_csr.sv
// Self-checking bench for zkr_seed_csr: directed scenarios plus randomized traffic
// compared against a queue-based model of the seed CSR status machine.
module tb_zkr_seed_csr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        es_valid_i;
  logic [15:0] es_data_i;
  logic [1:0]  es_error_i;
  logic        es_ready_o;
  logic        csr_rd_i, csr_wr_i, access_ok_i;
  logic [31:0] csr_rdata_o;
  logic        illegal_o;

  int n_tests = 0;
  int n_fail  = 0;

  // model: mode is the software-visible OPST value
  int          mode;
  int          bist_left;
  logic [15:0] fifo [$];

  zkr_seed_csr #(.FIFO_DEPTH(2), .BIST_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .es_valid_i(es_valid_i), .es_data_i(es_data_i), .es_error_i(es_error_i),
    .es_ready_o(es_ready_o),
    .csr_rd_i(csr_rd_i), .csr_wr_i(csr_wr_i), .access_ok_i(access_ok_i),
    .csr_rdata_o(csr_rdata_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = 0;
    bist_left = 15;
    fifo.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    es_valid_i = 1'b1; es_data_i = 16'hFFFF; es_error_i = 2'b00;
    csr_rd_i = 1'b1; csr_wr_i = 1'b0; access_ok_i = 1'b1;
    #1;
    chk("rst_ready", {31'b0, es_ready_o}, 32'h0);
    chk("rst_illegal", {31'b0, illegal_o}, 32'h0);
    chk("rst_rdata", csr_rdata_o, 32'h0);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    es_valid_i = 1'b0; csr_rd_i = 1'b0; csr_wr_i = 1'b0;
  endtask

  // One cycle: drive, check combinational outputs, advance model, clock.
  task automatic step(input logic v, input logic [15:0] d, input logic [1:0] e,
                      input logic rd, input logic wr, input logic ok);
    logic        exp_ready, acc, push;
    logic [31:0] exp_rdata;
    es_valid_i = v; es_data_i = d; es_error_i = e;
    csr_rd_i = rd; csr_wr_i = wr; access_ok_i = ok;
    #1;
    acc       = rd & wr & ok;
    exp_ready = (fifo.size() < 2) && (mode != 3) && (e == 2'b00);
    exp_rdata = 32'h0;
    if (acc) begin
      exp_rdata = {mode[1:0], 30'b0};
      if (mode == 2) exp_rdata[15:0] = fifo[0];
    end
    chk("ready", {31'b0, es_ready_o}, {31'b0, exp_ready});
    chk("rdata", csr_rdata_o, exp_rdata);
    chk("illegal", {31'b0, illegal_o}, {31'b0, rd & ~acc});
    push = v & exp_ready;
    if (e == 2'b11) begin
      mode = 3; fifo.delete();
    end else if (mode != 3 && e == 2'b01) begin
      mode = 0; bist_left = 15; fifo.delete();
    end else if (mode == 0) begin
      if (bist_left == 0) mode = 1; else bist_left--;
    end else if (mode == 1) begin
      if (fifo.size() > 0 && e == 2'b00) mode = 2;
      if (push) fifo.push_back(d);
    end else if (mode == 2) begin
      if (e == 2'b10) begin
        mode = 1; fifo.delete();
      end else begin
        if (acc) void'(fifo.pop_front());
        if (push) fifo.push_back(d);
        if (fifo.size() == 0) mode = 1;
      end
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd_acc();
    step(1'b0, 16'h0, 2'b00, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    es_valid_i = 1'b0; es_data_i = '0; es_error_i = '0;
    csr_rd_i = 1'b0; csr_wr_i = 1'b0; access_ok_i = 1'b0;
    @(negedge clk);
    do_reset();

    // BIST: flushed words, status reads 0 for 16 cycles then WAIT
    for (int i = 0; i < 16; i++) step(1'b1, 16'hA5A5, 2'b00, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) rd_acc();
    chk("wait_status", {30'b0, mode[1:0]}, 32'h1);

    // two words then an empty read
    step(1'b1, 16'h1234, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(1);
    rd_acc(); rd_acc(); rd_acc();

    // full FIFO back-pressure
    step(1'b1, 16'h1111, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h5555, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h5555, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h5555, 2'b00, 1'b1, 1'b1, 1'b1);
    step(1'b1, 16'h5555, 2'b00, 1'b0, 1'b0, 1'b0);
    rd_acc(); rd_acc(); rd_acc();

    // simultaneous push and pop at count 1
    step(1'b1, 16'h0F0F, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 16'h7777, 2'b00, 1'b1, 1'b1, 1'b1);
    rd_acc(); rd_acc();

    // illegal accesses leave the FIFO alone
    step(1'b1, 16'hCAFE, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 16'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0, 2'b00, 1'b1, 1'b1, 1'b0);
    rd_acc(); rd_acc();

    // fatal error, dead, reset out of ES16
    step(1'b1, 16'hABCD, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 16'h0, 2'b01, 1'b0, 1'b0, 1'b0);
    rd_acc();
    idle(16);
    rd_acc();
    step(1'b0, 16'h0, 2'b11, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h9999, 2'b00, 1'b1, 1'b1, 1'b1);
    step(1'b0, 16'h0, 2'b01, 1'b1, 1'b1, 1'b1);
    rd_acc();
    do_reset();
    idle(17);
    step(1'b1, 16'h4242, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("es16_before_rst", {30'b0, mode[1:0]}, 32'h2);
    do_reset();
    rd_acc();
    idle(16);
    rd_acc();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int          r;
      logic [1:0]  e;
      r = int'($urandom_range(0, 199));
      if      (r < 180) e = 2'b00;
      else if (r < 192) e = 2'b10;
      else if (r < 198) e = 2'b01;
      else              e = 2'b11;
      if ((mode == 3 && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0)
        do_reset();
      else
        step(($urandom_range(0, 99) < 60), 16'($urandom), e,
             ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 85),
             ($urandom_range(0, 99) < 90));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
